i2f_conv: RTL and testbench

I2F_CONV -- requirements
Module: i2f_conv

---
 rtl/i2f_conv.sv | 121 ++++++++++++
 tb/tb_i2f_conv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2f_conv.sv
// i2f_conv: 32-bit signed integer to IEEE-754 single-precision converter.
//
// Three-stage valid/ready pipeline:
//   S1  sign + |in_data|
//   S2  leading-zero count + left-normalised magnitude
//   S3  rounded, packed result (drives out_data / out_inexact)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     in_data valid
//   in_ready     converter accepts in_data this cycle
//   in_data      two's-complement signed integer
//   out_valid    out_data / out_inexact valid
//   out_ready    consumer accepts the result this cycle
//   out_data     single-precision result
//   out_inexact  result differs from the exact input value
//
// Build option: define I2F_ROUND_EN for round-to-nearest-even; otherwise
// the mantissa is truncated toward zero. Latency is the same either way.
module i2f_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  // Stage state
  logic        s1_vld, s1_sign;
  logic [31:0] s1_mag;
  logic        s2_vld, s2_sign, s2_zero;
  logic [4:0]  s2_lz;
  logic [30:0] s2_norm;   // norm[31] is implied 1 for nonzero values

  // Handshake: a stage moves forward when the stage below is empty or is
  // itself moving forward this cycle, so a full pipe still streams 1/clk.
  logic adv1, adv2, acc;
  assign adv2     = s2_vld & (~out_valid | out_ready);
  assign adv1     = s1_vld & (~s2_vld | adv2);
  assign in_ready = ~s1_vld | adv1;
  assign acc      = in_valid & in_ready;

  // S1 -> S2: leading-zero count and normalisation
  logic [4:0]  lz;
  logic [31:0] norm;
  logic        found;
  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && s1_mag[i]) begin
        lz    = 5'(31 - i);
        found = 1'b1;
      end
    end
    norm = s1_mag << lz;
  end

  // S2 -> S3: round and pack
  logic [7:0]  exp_raw, exp_r;
  logic [22:0] mant, mant_r;
  logic        guard, sticky, inc, carry;
  logic [31:0] res;
  logic        res_inx;
  always_comb begin
    exp_raw = 8'd158 - {3'b000, s2_lz};
    mant    = s2_norm[30:8];
    guard   = s2_norm[7];
    sticky  = |s2_norm[6:0];
`ifdef I2F_ROUND_EN
    inc     = guard & (sticky | mant[0]);
`else
    inc     = 1'b0;
`endif
    // All-ones mantissa + 1 carries into the exponent; max exponent is
    // 158 so this can never reach the infinity encoding.
    {carry, mant_r} = {1'b0, mant} + {23'd0, inc};
    exp_r   = exp_raw + {7'd0, carry};
    res     = s2_zero ? 32'd0 : {s2_sign, exp_r, mant_r};
    res_inx = ~s2_zero & (guard | sticky);
  end

  // Valid bits and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_inexact <= 1'b0;
    end else begin
      s1_vld    <= acc  | (s1_vld & ~adv1);
      s2_vld    <= adv1 | (s2_vld & ~adv2);
      out_valid <= adv2 | (out_valid & ~out_ready);
      if (adv2) begin
        out_data    <= res;
        out_inexact <= res_inx;
      end
    end
  end

  // Datapath registers need no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (acc) begin
      s1_sign <= in_data[31];
      s1_mag  <= in_data[31] ? (~in_data + 32'd1) : in_data;
    end
    if (adv1) begin
      s2_sign <= s1_sign;
      s2_lz   <= lz;
      s2_norm <= norm[30:0];
      s2_zero <= ~norm[31];   // only a zero magnitude leaves bit 31 clear
    end
  end

endmodule

// File: tb/tb_i2f_conv.sv
module tb_i2f_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  i2f_conv dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

`ifdef I2F_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inx;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single isolated conversion with a bounded wait for the result.
  task automatic run_vec(input int k);
    bit got;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = tbl[k].din;
    #1 chk("vec in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("vec%0d out_valid", k), {31'd0, got}, 32'd1);
    if (got) begin
      chk($sformatf("vec%0d data in=%h", k, tbl[k].din), out_data, tbl[k].dout);
      chk($sformatf("vec%0d inexact", k), {31'd0, out_inexact}, {31'd0, tbl[k].inx});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, nout;
    logic [31:0] held;
    bit seen;

    tbl[0]  = '{32'h00000001, 32'h3F800000, 1'b0};
    tbl[1]  = '{32'hFFFFFFFF, 32'hBF800000, 1'b0};
    tbl[2]  = '{32'h00000000, 32'h00000000, 1'b0};
    tbl[3]  = '{32'h80000000, 32'hCF000000, 1'b0};
    tbl[4]  = '{32'h7FFFFFFF, RND ? 32'h4F000000 : 32'h4EFFFFFF, 1'b1};
    tbl[5]  = '{32'h01000003, RND ? 32'h4B800002 : 32'h4B800001, 1'b1};
    tbl[6]  = '{32'h01000001, 32'h4B800000, 1'b1};
    tbl[7]  = '{32'h00000002, 32'h40000000, 1'b0};
    tbl[8]  = '{32'h00000003, 32'h40400000, 1'b0};
    tbl[9]  = '{32'hFFFFFFFE, 32'hC0000000, 1'b0};
    tbl[10] = '{32'h00000064, 32'h42C80000, 1'b0};
    tbl[11] = '{32'h00FFFFFF, 32'h4B7FFFFF, 1'b0};
    tbl[12] = '{32'h01000005, 32'h4B800002, 1'b1};
    tbl[13] = '{32'h01000007, RND ? 32'h4B800004 : 32'h4B800003, 1'b1};
    tbl[14] = '{32'hFFFFFF9C, 32'hC2C80000, 1'b0};
    tbl[15] = '{32'hFEFFFFFD, RND ? 32'hCB800002 : 32'hCB800001, 1'b1};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_inexact", {31'd0, out_inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, one at a time
    for (int k = 0; k < NV; k++) run_vec(k);

    // Back-to-back stream of 10: out_valid visible after the 3rd edge
    // following the first accept (sampled at iteration 3), then 10 in a row.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 10);
      in_data   = tbl[i % NV].din;
      #1;
      if (i < 10) chk($sformatf("stream in_ready %0d", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("stream out_valid @%0d", i), {31'd0, out_valid},
          {31'd0, (i >= 3 && i <= 12) ? 1'b1 : 1'b0});
      if (out_valid && i >= 3 && i <= 12)
        chk($sformatf("stream data %0d", i - 3), out_data, tbl[i - 3].dout);
    end
    in_valid = 1'b0;

    // Back-pressure: 5 offered, only 3 fit, output held stable
    acc = 0; seen = 1'b0; held = 32'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (acc < 5);
      in_data   = tbl[acc % NV].din;
      #1;
      if (out_valid) begin
        if (seen) chk("stall out_data stable", out_data, held);
        else begin held = out_data; seen = 1'b1; end
      end
      if (in_valid && in_ready) acc++;
    end
    chk("stall accepted", acc, 3);
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall held value", held, tbl[0].dout);
    nout = 0;
    for (int c = 0; c < 30 && nout < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (acc < 5);
      in_data   = tbl[acc % NV].din;
      #1;
      if (out_valid) begin
        chk($sformatf("drain data %0d", nout), out_data, tbl[nout].dout);
        nout++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    chk("drain count", nout, 5);

    // Reset with three items in flight
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = tbl[7 + i].din;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 if (out_valid) nout++;
    end
    chk("no stale results", nout, 0);
    run_vec(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
